// File: rtl/pacman_video_pkg.sv
// rtl/pacman_video_pkg.sv - shared video/frame-buffer constants and tile-fetch state type
package pacman_video_pkg;

    localparam int TILE_COLS = 28;
    localparam int TILE_ROWS = 36;

    localparam logic [15:0] FB_TILE_BASE  = 16'h4000;
    localparam logic [15:0] FB_COLOR_BASE = 16'h4400;

    localparam logic [4:0] LAST_COL = 5'(TILE_COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(TILE_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPT,
        OUT,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/pacman_tile_addr.sv
// rtl/pacman_tile_addr.sv - screen (col,row) to 11-bit frame-buffer offset
//
// Ports:
//   col    in  5   screen column 0..27
//   row    in  6   screen row 0..35
//   offset out 11  offset into the tile-code / color regions
module pacman_tile_addr
    import pacman_video_pkg::*;
(
    input  logic [4:0]  col,
    input  logic [5:0]  row,
    output logic [10:0] offset
);

    logic [10:0] col_w;
    logic [10:0] row_w;

    assign col_w = {6'd0, col};
    assign row_w = {5'd0, row};

    // The playfield (rows 2..33) is stored column-major and mirrored in x;
    // the two top and two bottom status rows are stored row-major, each
    // 32 entries wide with a 2-entry border on either side.
    always_comb begin
        if (row < 6'd2) begin
            offset = 11'h3C0 + (row_w << 5) + (11'd29 - col_w);
        end else if (row > 6'd33) begin
            offset = ((row_w - 11'd34) << 5) + (11'd29 - col_w);
        end else begin
            offset = 11'h040 + (({6'd0, LAST_COL} - col_w) << 5) + (row_w - 11'd2);
        end
    end

endmodule

// File: rtl/pacman_tile_fetch.sv
// rtl/pacman_tile_fetch.sv - per-frame raster walk of tile code/color from the frame buffer
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   frame_start            vblank pulse, starts a walk when idle
//   fb_douta / fb_doutb    frame-buffer read data (tile code / color byte)
//   tile_ready             renderer accepts the presented tile
//   gpu_addr_out1 / 2      tile-code / color read addresses, 0 when not reading
//   tile_valid + payload   tile_code, tile_color, tile_col, tile_row
//   busy, frame_done       walk in progress / one-cycle end-of-frame pulse
module pacman_tile_fetch
    import pacman_video_pkg::*;
#(
    parameter int COLOR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [7:0]         fb_douta,
    input  logic [7:0]         fb_doutb,
    input  logic               tile_ready,
    output logic [15:0]        gpu_addr_out1,
    output logic [15:0]        gpu_addr_out2,
    output logic               tile_valid,
    output logic [7:0]         tile_code,
    output logic [COLOR_W-1:0] tile_color,
    output logic [4:0]         tile_col,
    output logic [5:0]         tile_row,
    output logic               busy,
    output logic               frame_done
);

    fetch_state_t state, state_next;

    logic [4:0]  col_q;
    logic [5:0]  row_q;
    logic [10:0] offset;
    logic        last_tile;
    logic        cnt_clear;
    logic        cnt_advance;
    logic        capture;
    logic        drive_addr;

    pacman_tile_addr u_tile_addr (
        .col    (col_q),
        .row    (row_q),
        .offset (offset)
    );

    assign last_tile = (col_q == LAST_COL) && (row_q == LAST_ROW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_clear   = 1'b0;
        cnt_advance = 1'b0;
        capture     = 1'b0;
        drive_addr  = 1'b0;
        tile_valid  = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (frame_start) begin
                    cnt_clear  = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                drive_addr = 1'b1;
                state_next = CAPT;
            end
            CAPT: begin
                // Read data for the ADDR-cycle address is stable here.
                drive_addr = 1'b1;
                capture    = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                tile_valid = 1'b1;
                if (tile_ready) begin
                    if (last_tile) begin
                        state_next = DONE;
                    end else begin
                        cnt_advance = 1'b1;
                        state_next  = ADDR;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // A nonzero address is how the memory manager detects a GPU read, so
    // the buses must be exactly zero whenever the CPU should own the buffer.
    assign gpu_addr_out1 = drive_addr ? (FB_TILE_BASE  | {5'd0, offset}) : 16'h0000;
    assign gpu_addr_out2 = drive_addr ? (FB_COLOR_BASE | {5'd0, offset}) : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= 5'd0;
            row_q <= 6'd0;
        end else if (cnt_clear) begin
            col_q <= 5'd0;
            row_q <= 6'd0;
        end else if (cnt_advance) begin
            if (col_q == LAST_COL) begin
                col_q <= 5'd0;
                row_q <= row_q + 6'd1;
            end else begin
                col_q <= col_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_code  <= 8'd0;
            tile_color <= '0;
            tile_col   <= 5'd0;
            tile_row   <= 6'd0;
        end else if (capture) begin
            tile_code  <= fb_douta;
            tile_color <= fb_doutb[COLOR_W-1:0];
            tile_col   <= col_q;
            tile_row   <= row_q;
        end
    end

endmodule

// File: tb/tb_pacman_tile_fetch.sv
// tb/tb_pacman_tile_fetch.sv - randomized self-checking bench for pacman_tile_fetch
module tb_pacman_tile_fetch;

    localparam int COLOR_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               frame_start;
    logic [7:0]         fb_douta;
    logic [7:0]         fb_doutb;
    logic               tile_ready;
    logic [15:0]        gpu_addr_out1;
    logic [15:0]        gpu_addr_out2;
    logic               tile_valid;
    logic [7:0]         tile_code;
    logic [COLOR_W-1:0] tile_color;
    logic [4:0]         tile_col;
    logic [5:0]         tile_row;
    logic               busy;
    logic               frame_done;

    logic [4:0]  ta_col;
    logic [5:0]  ta_row;
    logic [10:0] ta_offset;

    logic [7:0] fb_mem [0:2047];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pacman_tile_fetch #(.COLOR_W(COLOR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_start   (frame_start),
        .fb_douta      (fb_douta),
        .fb_doutb      (fb_doutb),
        .tile_ready    (tile_ready),
        .gpu_addr_out1 (gpu_addr_out1),
        .gpu_addr_out2 (gpu_addr_out2),
        .tile_valid    (tile_valid),
        .tile_code     (tile_code),
        .tile_color    (tile_color),
        .tile_col      (tile_col),
        .tile_row      (tile_row),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    pacman_tile_addr u_tile_addr (
        .col    (ta_col),
        .row    (ta_row),
        .offset (ta_offset)
    );

    // Frame buffer: 0x4000 region at index 0x000, 0x4400 region at 0x400.
    always @(posedge clk) begin
        fb_douta <= fb_mem[gpu_addr_out1[10:0]];
        fb_doutb <= fb_mem[gpu_addr_out2[10:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_off(input int c, input int r);
        if (r >= 2 && r <= 33) return 'h040 + (27 - c) * 32 + (r - 2);
        else if (r < 2)        return 'h3C0 + r * 32 + (29 - c);
        else                   return (r - 34) * 32 + (29 - c);
    endfunction

    function automatic logic [23:0] model_payload(input int idx);
        int c;
        int r;
        int off;
        logic [7:0] code;
        logic [7:0] color;
        c = idx % 28;
        r = idx / 28;
        off = model_off(c, r);
        code = fb_mem[off];
        color = fb_mem[off + 'h400];
        return {code, color[COLOR_W-1:0], c[4:0], r[5:0]};
    endfunction

    function automatic logic [58:0] all_outputs();
        return {gpu_addr_out1, gpu_addr_out2, tile_valid, tile_code, tile_color,
                tile_col, tile_row, busy, frame_done};
    endfunction

    task automatic run_frame(input bit rnd, input int hold_idx, input int pulse_idx,
                             input int reset_idx, input bit start_in_done);
        int idx = 0;
        int cyc = 0;
        int hold_cnt = 0;
        int first_valid = -1;
        int addr_cycles = 0;
        int exp_off;
        bit fin = 0;
        bit aborted = 0;
        bit pulsed = 0;
        frame_start = 1'b1;
        tile_ready  = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        while (!fin && cyc < 20000) begin
            exp_off = model_off(idx % 28, idx / 28);
            if (cyc == 0)
                check("first_addr", {gpu_addr_out1, gpu_addr_out2}, {16'h43DD, 16'h47DD});
            if (gpu_addr_out1 != 16'h0 || gpu_addr_out2 != 16'h0) begin
                check("tile_addr", {gpu_addr_out1, gpu_addr_out2},
                      {16'h4000 | 16'(exp_off), 16'h4400 | 16'(exp_off)});
                check("addr_busy", busy, 1);
                addr_cycles++;
            end
            frame_start = (idx == pulse_idx && addr_cycles == 1 && !pulsed);
            if (frame_start) pulsed = 1;
            if (idx == reset_idx && addr_cycles == 2) begin
                reset = 1'b1;
                tile_ready = 1'b0;
                @(negedge clk);
                check("reset_mid_frame", all_outputs(), 0);
                reset = 1'b0;
                fin = 1;
                aborted = 1;
            end else begin
                if (tile_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    check("payload", {tile_code, tile_color, tile_col, tile_row}, model_payload(idx));
                    check("out_addr_zero", {gpu_addr_out1, gpu_addr_out2}, 0);
                    if (idx == hold_idx && hold_cnt < 20) begin
                        check("hold_payload", {tile_code, tile_color, tile_col, tile_row},
                              {8'hA5, 5'h1F, 5'd5, 6'd10});
                        tile_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (tile_ready) begin
                        idx++;
                        addr_cycles = 0;
                    end
                end else begin
                    tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (frame_done) begin
                    check("done_tiles", idx, 1008);
                    check("done_busy", busy, 1);
                    if (!rnd) check("first_valid_lat", first_valid, 2);
                    if (!rnd && hold_idx < 0) check("frame_cycles", cyc + 1, 3025);
                    if (hold_idx >= 0) check("hold_cycles", hold_cnt, 20);
                    frame_start = start_in_done;
                    fin = 1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) check("frame_timeout", 1, 0);
        frame_start = 1'b0;
        tile_ready  = 1'b0;
        if (!aborted) begin
            for (int i = 0; i < 20; i++) begin
                check("post_frame_idle", {busy, frame_done, tile_valid, gpu_addr_out1, gpu_addr_out2}, 0);
                @(negedge clk);
            end
        end
    endtask

    int   spot_c  [5] = '{0, 27, 27, 13, 0};
    int   spot_r  [5] = '{2, 33, 35, 1, 0};
    logic [15:0] spot_a [5] = '{16'h43A0, 16'h405F, 16'h4022, 16'h43F0, 16'h43DD};

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        tile_ready  = 1'b0;
        ta_col      = 5'd0;
        ta_row      = 6'd0;
        for (int i = 0; i < 2048; i++) fb_mem[i] = 8'($urandom);
        fb_mem[11'h308] = 8'hA5;
        fb_mem[11'h708] = 8'h3F;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b0;

        for (int r = 0; r < 36; r++) begin
            for (int c = 0; c < 28; c++) begin
                ta_col = 5'(c);
                ta_row = 6'(r);
                #1;
                check("map_offset", ta_offset, model_off(c, r));
            end
        end
        for (int i = 0; i < 5; i++) begin
            ta_col = 5'(spot_c[i]);
            ta_row = 6'(spot_r[i]);
            #1;
            check("map_spot", 16'h4000 | {5'd0, ta_offset}, spot_a[i]);
        end
        @(negedge clk);

        for (int i = 0; i < 100; i++) begin
            check("idle_bus", {busy, gpu_addr_out1, gpu_addr_out2}, 0);
            @(negedge clk);
        end

        run_frame(1'b0, -1, -1, -1, 1'b0);
        run_frame(1'b0, 285, 500, -1, 1'b1);
        run_frame(1'b1, -1, -1, 300, 1'b0);
        run_frame(1'b1, -1, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
